cell_score_calc: RTL and testbench
==================================

CELL_SCORE_CALC -- requirements
Module: cell_score_calc

Interface
REQ-001 Parameters: N, default 128, sequence length; MATCH, default 1, signed score added on symbol match; MISMATCH, default -1, signed score added on mismatch; GAP, default -1, signed gap penalty; RD_LAT, default 2, cycles from en_read/count to valid ram_dout; SW, default $clog2(N+1)+3, signed score width.
REQ-002 Derived: BitAddr = $clog2(N+1); addr_lenght = $clog2(((N+1)*(N+1))-1).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to compute cell (i+1, j+1).
REQ-006 i, j  in  BitAddr+1 each  zero-based cell indices; sampled with start.
REQ-007 is_match  in  1  1 = symbols equal; sampled with start.
REQ-008 ram_dout  in  SW  signed score RAM read data.
REQ-009 en_read  out  1  read enable to the read-index stage.
REQ-010 count  out  2  read selector: 0 diagonal, 1 left, 2 up.
REQ-011 busy  out  1  high from the cycle after start is accepted until done.
REQ-012 wr_en  out  1  score RAM write strobe.
REQ-013 wr_addr  out  addr_lenght+1  write address.
REQ-014 score_out  out  SW  signed cell score.
REQ-015 dir_out  out  2  traceback: 00 diag, 01 left, 10 up.
REQ-016 done  out  1  one-cycle completion pulse, coincident with wr_en.

Function
REQ-017 FSM states: IDLE, READ, WAIT, CALC, WRITE; all outputs registered.
REQ-018 IDLE: start=1 latches i, j, is_match and moves to READ; start=0 stays in IDLE.
REQ-019 READ: 3 cycles; en_read=1; count=0, then 1, then 2; then moves to WAIT.
REQ-020 WAIT: RD_LAT cycles, en_read=0; then moves to CALC.
REQ-021 Data for count k is captured from ram_dout exactly RD_LAT cycles after the cycle in which count=k was driven; tag tracking via a RD_LAT-deep shift register of (valid, count).
REQ-022 CALC: d = diag + (is_match ? MATCH : MISMATCH); l = left + GAP; u = up + GAP; score = max(d, u, l), computed in SW-bit signed arithmetic with no saturation.
REQ-023 Tie priority: diag over up over left; dir_out encodes the winner.
REQ-024 WRITE: 1 cycle; wr_en=1, done=1, wr_addr = (j+1)+(N+1)*(i+1), score_out and dir_out valid; then returns to IDLE.
REQ-025 Latency: done asserts 5+RD_LAT cycles after the start-sampling edge (7 at default); the next start is accepted in the first IDLE cycle after WRITE.
REQ-026 start while busy is ignored; no queuing.
REQ-027 score_out and dir_out hold their values after WRITE until the next WRITE.
REQ-028 Outside READ: en_read=0, count=0.

Reset
REQ-029 rst=0 forces IDLE asynchronously: en_read, count, busy, wr_en, wr_addr, score_out, dir_out, done and the capture registers all 0.
REQ-030 Reset mid-operation aborts the cell with no wr_en and no done; the first start after release begins a fresh cell.

Structure
REQ-031 Shared package holds state encoding, dir codes (DIR_DIAG, DIR_LEFT, DIR_UP) and the count codes shared with the read-index stage.
REQ-032 One sub-module, score_max3: combinational signed max-of-three with tie priority, returning value and dir.

Verification
REQ-033 i=0, j=0, is_match=1, ram returns diag=3, left=1, up=2 -> score_out=4, dir=00, wr_addr=130, done exactly 7 cycles after start.
REQ-034 is_match=0, diag=3, left=1, up=5 -> d=2, u=4, l=0 -> score_out=4, dir=10.
REQ-035 is_match=0, diag=0, left=0, up=0 -> all candidates -1 -> score_out=-1, dir=00 (tie priority).
REQ-036 is_match=0, diag=-5, left=-3, up=-4 -> score_out=-4, dir=01; i=127, j=127 -> wr_addr=16640.
REQ-037 start pulsed again in the 3rd busy cycle -> ignored, exactly one done; rst=0 during WAIT -> no wr_en, outputs 0, next start completes normally.

Source files
------------

// File: rtl/cell_score_calc_pkg.sv
// cell_score_calc_pkg: shared FSM states, traceback directions and read-selector codes
package cell_score_calc_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE} state_t;
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_DIAG = 2'b00;
  localparam dir_t DIR_LEFT = 2'b01;
  localparam dir_t DIR_UP   = 2'b10;
  localparam logic [1:0] CNT_DIAG = 2'd0;
  localparam logic [1:0] CNT_LEFT = 2'd1;
  localparam logic [1:0] CNT_UP   = 2'd2;
endpackage

// File: rtl/cell_score_calc_if.sv
// cell_score_calc_if: request, score-RAM read and result signals of one cell computation
interface cell_score_calc_if #(
  parameter int N  = 128,
  parameter int SW = $clog2(N+1)+3
);
  localparam int BitAddr     = $clog2(N+1);
  localparam int addr_lenght = $clog2(((N+1)*(N+1))-1);
  logic                    start;
  logic [BitAddr:0]        i;
  logic [BitAddr:0]        j;
  logic                    is_match;
  logic signed [SW-1:0]    ram_dout;
  logic                    en_read;
  logic [1:0]              count;
  logic                    busy;
  logic                    wr_en;
  logic [addr_lenght:0]    wr_addr;
  logic signed [SW-1:0]    score_out;
  logic [1:0]              dir_out;
  logic                    done;
  modport master (
    output start, i, j, is_match, ram_dout,
    input  en_read, count, busy, wr_en, wr_addr, score_out, dir_out, done
  );
  modport slave (
    input  start, i, j, is_match, ram_dout,
    output en_read, count, busy, wr_en, wr_addr, score_out, dir_out, done
  );
endinterface

// File: rtl/cell_score_calc_score_max3.sv
// score_max3: signed max of three candidates, ties resolved diag > up > left
module score_max3
  import cell_score_calc_pkg::*;
#(
  parameter int SW = 11
) (
  input  logic signed [SW-1:0] d,
  input  logic signed [SW-1:0] l,
  input  logic signed [SW-1:0] u,
  output logic signed [SW-1:0] best,
  output dir_t                 dir
);
  always_comb begin
    dir  = (d >= u && d >= l) ? DIR_DIAG : (u >= l) ? DIR_UP : DIR_LEFT;
    best = (dir == DIR_DIAG) ? d : (dir == DIR_UP) ? u : l;
  end
endmodule

// File: rtl/cell_score_calc.sv
// cell_score_calc: fetches diag/left/up neighbours, scores one alignment cell and writes it back
module cell_score_calc
  import cell_score_calc_pkg::*;
#(
  parameter int N        = 128,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -1,
  parameter int RD_LAT   = 2,
  parameter int SW       = $clog2(N+1)+3
) (
  input logic             clk,
  input logic             rst,
  cell_score_calc_if.slave bus
);
  localparam int BitAddr = $clog2(N+1);
  localparam int AW      = $clog2(((N+1)*(N+1))-1)+1;
  localparam int WW      = $clog2(RD_LAT+1);
  state_t                   state, nxt;
  logic [BitAddr:0]         i_q, j_q;
  logic                     m_q;
  logic signed [SW-1:0]     diag, left, up, d_s, l_s, u_s, best;
  dir_t                     bdir;
  logic [RD_LAT-1:0]        pv;
  logic [RD_LAT-1:0][1:0]   pc;
  logic [WW-1:0]            wc, wc_d;
  logic                     en_d;
  logic [1:0]               cnt_d;
  logic [AW-1:0]            addr;
  assign d_s  = diag + (m_q ? SW'(MATCH) : SW'(MISMATCH));
  assign l_s  = left + SW'(GAP);
  assign u_s  = up + SW'(GAP);
  assign addr = AW'(j_q) + AW'(1) + AW'(N+1) * (AW'(i_q) + AW'(1));
  score_max3 #(.SW(SW)) u_max (.d(d_s), .l(l_s), .u(u_s), .best(best), .dir(bdir));
  always_comb begin
    nxt   = state;
    en_d  = 1'b0;
    cnt_d = CNT_DIAG;
    wc_d  = '0;
    case (state)
      IDLE:    if (bus.start) begin
                 nxt  = READ;
                 en_d = 1'b1;
               end
      READ:    if (bus.count == CNT_UP) nxt = WAIT;
               else begin
                 en_d  = 1'b1;
                 cnt_d = bus.count + 2'd1;
               end
      WAIT:    if (wc == WW'(RD_LAT-1)) nxt = CALC;
               else wc_d = wc + WW'(1);
      CALC:    nxt = WRITE;
      WRITE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // read tags travel RD_LAT stages so each returning word lands in its own register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wc            <= '0;
      i_q           <= '0;
      j_q           <= '0;
      m_q           <= 1'b0;
      pv            <= '0;
      pc            <= '0;
      diag          <= '0;
      left          <= '0;
      up            <= '0;
      bus.en_read   <= 1'b0;
      bus.count     <= '0;
      bus.busy      <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.done      <= 1'b0;
      bus.wr_addr   <= '0;
      bus.score_out <= '0;
      bus.dir_out   <= '0;
    end else begin
      state       <= nxt;
      wc          <= wc_d;
      bus.en_read <= en_d;
      bus.count   <= cnt_d;
      bus.busy    <= nxt != IDLE;
      bus.wr_en   <= nxt == WRITE;
      bus.done    <= nxt == WRITE;
      pv          <= RD_LAT'({pv, bus.en_read});
      pc          <= (2*RD_LAT)'({pc, bus.count});
      if (state == IDLE && bus.start) begin
        i_q <= bus.i;
        j_q <= bus.j;
        m_q <= bus.is_match;
      end
      if (pv[RD_LAT-1] && pc[RD_LAT-1] == CNT_DIAG) diag <= bus.ram_dout;
      if (pv[RD_LAT-1] && pc[RD_LAT-1] == CNT_LEFT) left <= bus.ram_dout;
      if (pv[RD_LAT-1] && pc[RD_LAT-1] == CNT_UP)   up   <= bus.ram_dout;
      if (state == CALC) begin
        bus.score_out <= best;
        bus.dir_out   <= bdir;
        bus.wr_addr   <= addr;
      end
    end
  end
endmodule

// File: tb/tb_cell_score_calc.sv
// tb_cell_score_calc: directed cells with a scoreboard checked whenever done pulses
module tb_cell_score_calc;
  localparam int N = 128;
  localparam int RD_LAT = 2;
  localparam int SW = 11;
  typedef struct {int score; int dir; int addr;} exp_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0, pass = 0, done_cnt = 0, n;
  exp_t sb[$];
  int vals[3];
  logic p1v = 1'b0, p2v = 1'b0;
  logic [1:0] p1c = '0, p2c = '0;
  cell_score_calc_if #(.N(N)) bus();
  cell_score_calc #(.N(N), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // score RAM: returns the selected neighbour RD_LAT cycles after the request, junk otherwise
  always @(posedge clk) begin
    p1v <= bus.en_read;
    p1c <= bus.count;
    p2v <= p1v;
    p2c <= p1c;
  end
  assign bus.ram_dout = p2v ? SW'(vals[p2c]) : SW'(300);
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("score", int'(bus.score_out), e.score);
        chk("dir", int'(bus.dir_out), e.dir);
        chk("wr_addr", int'(bus.wr_addr), e.addr);
        chk("wr_en", int'(bus.wr_en), 1);
      end
    end
  end
  task automatic do_cell(input int ii, input int jj, input bit m, input int d, input int l,
                         input int u, input int es, input int ed, input int ea, input bit glitch);
    int lat;
    lat = -1;
    vals[0] = d;
    vals[1] = l;
    vals[2] = u;
    sb.push_back('{es, ed, ea});
    @(negedge clk);
    bus.i = 9'(ii);
    bus.j = 9'(jj);
    bus.is_match = m;
    bus.start = 1'b1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      bus.start = glitch && k == 3;
      if (k == 1) begin
        chk("busy_c1", int'(bus.busy), 1);
        chk("en_read_c1", int'(bus.en_read), 1);
        chk("count_c1", int'(bus.count), 0);
      end
      if (k == 4) chk("en_read_wait", int'(bus.en_read), 0);
      if (bus.done) lat = k;
    end
    chk("latency", lat, 7);
    repeat (3) @(negedge clk);
    chk("hold_score", int'(bus.score_out), es);
    chk("hold_dir", int'(bus.dir_out), ed);
    chk("idle_busy", int'(bus.busy), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.i = '0;
    bus.j = '0;
    bus.is_match = 1'b0;
    vals = '{0, 0, 0};
    repeat (3) @(negedge clk);
    chk("rst_en_read", int'(bus.en_read), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_score", int'(bus.score_out), 0);
    chk("rst_dir", int'(bus.dir_out), 0);
    rst = 1'b1;
    do_cell(0, 0, 1, 3, 1, 2, 4, 0, 130, 0);
    do_cell(1, 2, 0, 3, 1, 5, 4, 2, 261, 0);
    do_cell(5, 3, 0, 0, 0, 0, -1, 0, 778, 0);
    do_cell(127, 127, 0, -5, -3, -4, -4, 1, 16640, 0);
    do_cell(2, 0, 1, 1, 0, 3, 2, 0, 388, 0);
    do_cell(0, 1, 0, 0, 4, 4, 3, 2, 131, 0);
    n = done_cnt;
    do_cell(3, 4, 1, 10, 0, 0, 11, 0, 521, 1);
    repeat (10) @(negedge clk);
    chk("glitch_one_done", done_cnt - n, 1);
    vals = '{7, 7, 7};
    @(negedge clk);
    bus.i = 9'd9;
    bus.j = 9'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n = done_cnt;
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_en_read", int'(bus.en_read), 0);
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_score", int'(bus.score_out), 0);
    chk("abort_wr_addr", int'(bus.wr_addr), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - n, 0);
    do_cell(4, 4, 1, -2, 0, 0, -1, 0, 650, 0);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
